// File: rtl/bka_seq_pkg.sv
// Shared constants and types for the wide-operand Brent-Kung add sequencer.
// Optional subtract mode in the top is enabled by BKA_WIDE_ADD_SEQ_SUB_EN.
package bka_seq_pkg;

    localparam int WORD_W = 22;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int idx_w(input int words);
        return ($clog2(words) < 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/bka_add_core.sv
// Combinational WORD_W-bit Brent-Kung adder with carry-in.
// res holds {carry-out, sum}.
module bka_add_core
    import bka_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W:0]   res
);

    localparam int N  = WORD_W;
    localparam int LV = $clog2(N);

    logic [N-1:0] pr;
    logic [N-1:0] g;
    logic [N-1:0] p;

    assign pr = a ^ b;

    // g[i] ends up as the carry out of bit i; cin folds into bit 0
    always_comb begin
        g    = a & b;
        p    = pr;
        g[0] = g[0] | (p[0] & cin);
        for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < N; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                    p[i] = p[i] & p[i - (1 << l)];
                end
            end
        end
        for (int l = LV - 2; l >= 0; l--) begin
            for (int i = 0; i < N; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l))
                    && ((i + 1) > (2 << l))) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << l)]);
                end
            end
        end
    end

    assign res = {g[N-1], pr ^ {g[N-2:0], cin}};

endmodule

// File: rtl/bka_wide_add_seq.sv
// Wide adder streaming WORDS x 22-bit slices through one Brent-Kung core.
// Define BKA_WIDE_ADD_SEQ_SUB_EN to add the in_sub (A-B) port.
module bka_wide_add_seq
    import bka_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDS*WORD_W-1:0] in_a,
    input  logic [WORDS*WORD_W-1:0] in_b,
`ifdef BKA_WIDE_ADD_SEQ_SUB_EN
    input  logic                    in_sub,
`endif
    input  logic                    in_cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORDS*WORD_W-1:0] out_sum,
    output logic                    out_cout,
    output logic                    busy
);

    localparam int W  = WORDS * WORD_W;
    localparam int IW = idx_w(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t            state;
    logic [IW-1:0]     idx;
    logic              cy;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              sub_q;
    logic [WORD_W-1:0] a_s;
    logic [WORD_W-1:0] b_s;
    logic [WORD_W:0]   res;

`ifndef BKA_WIDE_ADD_SEQ_SUB_EN
    assign sub_q = 1'b0;
`endif

    assign a_s = a_q[idx*WORD_W +: WORD_W];
    assign b_s = b_q[idx*WORD_W +: WORD_W] ^ {WORD_W{sub_q}};

    bka_add_core u_core (
        .a   (a_s),
        .b   (b_s),
        .cin (cy),
        .res (res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cy        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
`ifdef BKA_WIDE_ADD_SEQ_SUB_EN
            sub_q     <= 1'b0;
`endif
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        idx      <= '0;
`ifdef BKA_WIDE_ADD_SEQ_SUB_EN
                        sub_q    <= in_sub;
                        cy       <= in_sub ? 1'b1 : in_cin;
`else
                        cy       <= in_cin;
`endif
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    out_sum[idx*WORD_W +: WORD_W] <= res[WORD_W-1:0];
                    cy <= res[WORD_W];
                    if (idx == LAST) begin
                        out_cout  <= res[WORD_W];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
